mag_sched: RTL and testbench
============================

# mag_sched

Scheduler sharing one 16-bit vector-magnitude unit (sqrt(x²+y²+z²)) between two sample streams: requester 0 (accelerometer) and requester 1 (gyroscope). It accepts one sample at a time with round-robin arbitration and drives the unit's start pulse and operands. It waits for the unit's result, with an optional timeout, and returns the result tagged with its source on a valid/ready output. It sits between the sensor-sampling front end and the fall-decision feature logic.

## Interface
- DW, 16, operand/result width per axis
- TIMEOUT_CYC, 64, max cycles in WAIT before timeout (≥2; used only with MAG_TIMEOUT_EN)

- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- s0_valid  in  1  requester 0 sample valid
- s0_xyz  in  3*DW  requester 0 operands {z,y,x}, x in [DW-1:0]
- s0_ready  out  1  requester 0 accepted this cycle
- s1_valid / s1_xyz / s1_ready  in/in/out  1/3*DW/1  same for requester 1
- mag_start  out  1  one-cycle start pulse to magnitude unit
- mag_x, mag_y, mag_z  out  DW each  operands, stable from start until result/timeout
- mag_result  in  DW  unit result
- mag_valid  in  1  unit result valid
- m_valid  out  1  result available
- m_ready  in  1  consumer accepts
- m_mag  out  DW  magnitude (0 on timeout)
- m_src  out  1  source requester of m_mag
- m_err  out  1  1 = timeout, m_mag invalid
- busy  out  1  high in any state except IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, OUT. Reset state is IDLE.
- Reset values: all outputs 0, rr pointer 0 (requester 0 preferred first), timeout counter 0, operand registers 0.
- IDLE:
  - grant = the only valid requester; if both are valid, grant = rr.
  - sN_ready = (state==IDLE) && granted N. This is combinational and is never high for both requesters.
  - On accept: latch sN_xyz into mag_x/y/z, latch src=N, set rr <= ~N, go to ISSUE.
  - No valid requester → stay in IDLE; rr unchanged.
- ISSUE: mag_start=1 for exactly this cycle. mag_valid is ignored in this cycle (stale). Go to WAIT; counter <= 0.
- WAIT:
  - mag_valid=1 → m_mag <= mag_result, m_err <= 0, go to OUT.
  - Else the counter increments. When the counter == TIMEOUT_CYC-1 without mag_valid → m_mag <= 0, m_err <= 1, go to OUT.
  - If mag_valid and timeout coincide, mag_valid wins (m_err=0).
- OUT:
  - m_valid=1; m_mag, m_src and m_err are held stable until m_valid&&m_ready.
  - On handshake go to IDLE, m_valid <= 0.
  - No new request is accepted before the transition to IDLE (single outstanding operation).
- mag_valid is ignored outside WAIT.
- mag_x/y/z keep their last operands outside active operation. They change only on accept.
- Asserting reset_n low in any state returns to the reset values immediately:
  - a pending m_valid is dropped;
  - a mag_start pulse is never issued after reset.

## Timing
- Accept in cycle T (IDLE, sN_valid&&sN_ready).
- mag_start is high in T+1.
- The earliest mag_valid honoured is in T+2, giving m_valid=1 in T+3.
- Minimum turnaround, with m_ready held high: IDLE again at T+4, next accept at T+4. One sample every 4 cycles plus the unit latency.
- Timeout case: m_valid with m_err=1 in T+2+TIMEOUT_CYC.
- With both requesters continuously valid, grants alternate 0,1,0,1,… No starvation.

## Configuration
- MAG_TIMEOUT_EN defined:
  - The timeout counter and error path are built as described above.
- MAG_TIMEOUT_EN undefined:
  - No counter; WAIT leaves only on mag_valid and may wait indefinitely.
  - m_err is tied to 0.
  - TIMEOUT_CYC is unused.

## Test plan
- Reset → all outputs 0, busy=0. A single s0 request with xyz={0,4,3} and mag_valid=1 returning 5 three cycles after the start pulse → m_valid with m_mag=5, m_src=0, m_err=0. mag_start is high for exactly 1 cycle.
- s0 and s1 both valid, held for 4 operations → grant order 0,1,0,1. m_src matches the grant order and operands are routed correctly.
- m_ready low for 10 cycles in OUT → m_mag/m_src/m_err stable; no s*_ready asserted; mag_start is not pulsed.
- MAG_TIMEOUT_EN, TIMEOUT_CYC=8, mag_valid never asserted → m_valid at accept+10 with m_mag=0, m_err=1. The next request then completes normally.
- mag_valid asserted in the ISSUE cycle and in IDLE → ignored. Only a WAIT-cycle mag_valid produces the result.
- reset_n pulsed low during WAIT → immediate return to IDLE with outputs 0. A late mag_valid after reset produces no m_valid.

Source files
------------

// File: rtl/mag_sched.sv
// Round-robin scheduler that shares one vector-magnitude unit between two sample streams.
// Define MAG_TIMEOUT_EN to build the WAIT timeout counter and the m_err error path.
module mag_sched #(
  parameter int DW          = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            s0_valid,
  input  logic [3*DW-1:0] s0_xyz,
  output logic            s0_ready,
  input  logic            s1_valid,
  input  logic [3*DW-1:0] s1_xyz,
  output logic            s1_ready,
  output logic            mag_start,
  output logic [DW-1:0]   mag_x,
  output logic [DW-1:0]   mag_y,
  output logic [DW-1:0]   mag_z,
  input  logic [DW-1:0]   mag_result,
  input  logic            mag_valid,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [DW-1:0]   m_mag,
  output logic            m_src,
  output logic            m_err,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

  state_t          state, state_nx;
  logic            rr;
  logic            src;
  logic            grant_any;
  logic            grant_sel;
  logic            timeout_hit;
  logic [3*DW-1:0] grant_xyz;

  if (TIMEOUT_CYC < 2) begin : g_param_check
    $error("mag_sched: TIMEOUT_CYC must be at least 2");
  end

  // rr only breaks ties; a lone requester is granted regardless of the pointer.
  assign grant_any = s0_valid | s1_valid;
  assign grant_sel = (s0_valid && s1_valid) ? rr : s1_valid;
  assign grant_xyz = grant_sel ? s1_xyz : s0_xyz;

  assign s0_ready  = (state == IDLE) && grant_any && !grant_sel;
  assign s1_ready  = (state == IDLE) && grant_any &&  grant_sel;
  assign mag_start = (state == ISSUE);
  assign m_valid   = (state == OUT);
  assign busy      = (state != IDLE);
  assign m_src     = src;

`ifdef MAG_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC);

  logic [CW-1:0] cnt;
  logic          err_q;

  assign timeout_hit = (cnt == CW'(TIMEOUT_CYC - 1));
  assign m_err       = err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == ISSUE) begin
        cnt <= '0;
      end else if (state == WAIT) begin
        if (mag_valid) begin
          err_q <= 1'b0;
        end else if (timeout_hit) begin
          err_q <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign m_err       = 1'b0;
`endif

  // NOTE: every combinational output gets a default before the case so no path can infer a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (grant_any)                 state_nx = ISSUE;
      ISSUE:                                  state_nx = WAIT;
      WAIT:    if (mag_valid || timeout_hit)  state_nx = OUT;
      OUT:     if (m_ready)                   state_nx = IDLE;
      default:                                state_nx = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr    <= 1'b0;
      src   <= 1'b0;
      mag_x <= '0;
      mag_y <= '0;
      mag_z <= '0;
      m_mag <= '0;
    end else begin
      if (state == IDLE && grant_any) begin
        mag_x <= grant_xyz[DW-1:0];
        mag_y <= grant_xyz[2*DW-1:DW];
        mag_z <= grant_xyz[3*DW-1:2*DW];
        src   <= grant_sel;
        rr    <= ~grant_sel;
      end
      // A result arriving on the timeout cycle still wins over the error.
      if (state == WAIT) begin
        if (mag_valid) begin
          m_mag <= mag_result;
        end else if (timeout_hit) begin
          m_mag <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mag_sched.sv
// Bench for mag_sched: timestamp-based transaction model checked every cycle, plus directed pins.
// Build with and without MAG_TIMEOUT_EN; the timeout scenario runs only when it is defined.
module tb_mag_sched;
  localparam int DW = 16;
  localparam int TC = 8;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            s0_valid, s1_valid, s0_ready, s1_ready;
  logic [3*DW-1:0] s0_xyz, s1_xyz;
  logic            mag_start, mag_valid;
  logic [DW-1:0]   mag_x, mag_y, mag_z, mag_result;
  logic            m_valid, m_ready, m_src, m_err, busy;
  logic [DW-1:0]   m_mag;

  mag_sched #(.DW(DW), .TIMEOUT_CYC(TC)) dut (
    .clk(clk), .reset_n(reset_n),
    .s0_valid(s0_valid), .s0_xyz(s0_xyz), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_xyz(s1_xyz), .s1_ready(s1_ready),
    .mag_start(mag_start), .mag_x(mag_x), .mag_y(mag_y), .mag_z(mag_z),
    .mag_result(mag_result), .mag_valid(mag_valid),
    .m_valid(m_valid), .m_ready(m_ready), .m_mag(m_mag), .m_src(m_src),
    .m_err(m_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Transaction model: one outstanding job described by its accept cycle and result state.
  int              cyc = 0;
  bit              active, done, rr, msrc, rerr;
  int              acc_cyc;
  logic [3*DW-1:0] exyz;
  logic [DW-1:0]   res;
  bit              dut_log[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic int grant_of(input bit v0, input bit v1, input bit ptr);
    if (v0 && v1) return int'(ptr);
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    active = 0; done = 0; rr = 0; msrc = 0; rerr = 0;
    exyz = '0; res = '0; acc_cyc = -100;
  endtask

  // Called at a falling edge with inputs already driven; checks, then advances the model one cycle.
  task automatic step();
    int g;
    #1;
    g = active ? -1 : grant_of(s0_valid, s1_valid, rr);
    check("s0_ready", 64'(s0_ready), 64'(g == 0));
    check("s1_ready", 64'(s1_ready), 64'(g == 1));
    check("busy", 64'(busy), 64'(active));
    check("mag_start", 64'(mag_start), 64'(active && cyc == acc_cyc + 1));
    check("mag_zyx", 64'({mag_z, mag_y, mag_x}), 64'(exyz));
    check("m_valid", 64'(m_valid), 64'(done));
    if (done) begin
      check("m_mag", 64'(m_mag), 64'(res));
      check("m_src", 64'(m_src), 64'(msrc));
      check("m_err", 64'(m_err), 64'(rerr));
    end
    if (s0_ready) dut_log.push_back(1'b0);
    if (s1_ready) dut_log.push_back(1'b1);

    if (!active) begin
      if (g >= 0) begin
        active  = 1;
        acc_cyc = cyc;
        msrc    = g[0];
        exyz    = g[0] ? s1_xyz : s0_xyz;
        rr      = ~g[0];
      end
    end else if (!done) begin
      if (cyc >= acc_cyc + 2) begin
        if (mag_valid) begin
          done = 1; res = mag_result; rerr = 0;
        end
`ifdef MAG_TIMEOUT_EN
        else if (cyc == acc_cyc + 1 + TC) begin
          done = 1; res = '0; rerr = 1;
        end
`endif
      end
    end else if (m_ready) begin
      active = 0; done = 0;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    s0_valid = 0; s1_valid = 0; s0_xyz = '0; s1_xyz = '0;
    mag_valid = 0; mag_result = '0; m_ready = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_outs"},
          64'({s0_ready, s1_ready, mag_start, m_valid, m_src, m_err, busy}), 64'(0));
    check({tag, "_regs"}, 64'({mag_z, mag_y, mag_x}), 64'(0));
    check({tag, "_mmag"}, 64'(m_mag), 64'(0));
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic pulse_reset(input string tag);
    idle_inputs();
    #2 reset_n = 0;
    #1 check_reset_outputs(tag);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1;
  endtask

  // Steps until m_valid is seen, returning the number of steps taken (bounded).
  task automatic wait_result(output int n);
    n = 1;
    while (n < 60) begin
      #1;
      if (m_valid) break;
      step();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    idle_inputs();
    model_reset();
    reset_n = 0;
    #1 check_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1;

    // Single s0 request, result 5 returned three cycles after the start pulse, consumer stalls.
    s0_valid = 1; s0_xyz = {16'd0, 16'd4, 16'd3};
    step();
    s0_valid = 0;
    #1 check("t1_start", 64'(mag_start), 64'(1));
    step();
    step(); step();
    mag_valid = 1; mag_result = 16'd5;
    step();
    mag_valid = 0; mag_result = 16'd77;
    #1 check("t1_mag", 64'(m_mag), 64'(5));
    check("t1_ops", 64'({mag_y, mag_x}), 64'({16'd4, 16'd3}));
    s0_valid = 1; s1_valid = 1; s1_xyz = 48'h1111_2222_3333;
    repeat (10) step();
    check("t1_held", 64'({m_valid, m_src, m_err, m_mag}), 64'({1'b1, 1'b0, 1'b0, 16'd5}));
    s0_valid = 0; s1_valid = 0; m_ready = 1;
    step();

    // Both requesters held valid after reset: grants must alternate starting with 0.
    pulse_reset("rst_a");
    s0_valid = 1; s1_valid = 1; m_ready = 1; mag_valid = 1;
    dut_log.delete();
    for (int i = 0; i < 16; i++) begin
      s0_xyz = {$urandom, $urandom};
      s1_xyz = {$urandom, $urandom};
      mag_result = DW'($urandom);
      step();
    end
    check("rr_count", 64'(dut_log.size()), 64'(4));
    if (dut_log.size() == 4) begin
      check("rr_order", 64'({dut_log[0], dut_log[1], dut_log[2], dut_log[3]}), 64'(4'b0101));
    end

`ifdef MAG_TIMEOUT_EN
    // No result from the unit: error result at accept+TC+2, then a normal job completes.
    pulse_reset("rst_b");
    s1_valid = 1; s1_xyz = 48'h0001_0002_0003;
    step();
    s1_valid = 0;
    wait_result(n);
    check("to_latency", 64'(n), 64'(TC + 2));
    check("to_result", 64'({m_err, m_mag}), 64'({1'b1, 16'd0}));
    m_ready = 1;
    step();
    s0_valid = 1; s0_xyz = 48'h0009_0008_0007;
    step();
    s0_valid = 0; mag_valid = 1; mag_result = 16'h1234;
    wait_result(n);
    check("to_recover", 64'({m_err, m_src, m_mag}), 64'({1'b0, 1'b0, 16'h1234}));
    mag_valid = 0;
    step();
`endif

    // Reset during WAIT, followed by a late unit result that must be ignored.
    pulse_reset("rst_c");
    s0_valid = 1; s0_xyz = 48'h0005_0006_0007;
    step();
    s0_valid = 0;
    step(); step();
    #1 check("w_busy", 64'(busy), 64'(1));
    pulse_reset("rst_w");
    mag_valid = 1; mag_result = 16'hbeef;
    repeat (4) step();
    mag_valid = 0;

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      s0_valid   = ($urandom_range(0, 2) != 0);
      s1_valid   = ($urandom_range(0, 2) != 0);
      s0_xyz     = {$urandom, $urandom};
      s1_xyz     = {$urandom, $urandom};
      mag_valid  = ($urandom_range(0, 4) == 0);
      mag_result = DW'($urandom);
      m_ready    = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
